// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcode/funct
// values, ALUOp and ALU control codes, and datapath mux selects.
package multicycle_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10,
        AluOpRsvd  = 2'b11
    } aluop_e;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps ALUOp and the R-type funct field onto the 3-bit ALU control.
module alu_decoder
    import multicycle_pkg::*;
#(
    parameter int unsigned FUNCT_W  = 6,
    parameter int unsigned ALUCTL_W = 3
) (
    input  aluop_e              aluop,
    input  logic [FUNCT_W-1:0]  funct,
    output logic [ALUCTL_W-1:0] alu_ctl
);

    always_comb begin
        alu_ctl = ALU_ADD;
        case (aluop)
            AluOpSub: alu_ctl = ALU_SUB;
            AluOpFunct: begin
                case (funct)
                    FUNCT_ADD: alu_ctl = ALU_ADD;
                    FUNCT_SUB: alu_ctl = ALU_SUB;
                    FUNCT_AND: alu_ctl = ALU_AND;
                    FUNCT_OR:  alu_ctl = ALU_OR;
                    FUNCT_SLT: alu_ctl = ALU_SLT;
                    default:   alu_ctl = ALU_ADD;
                endcase
            end
            default: alu_ctl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle MIPS datapath (Moore on opcode).
// Optional memory handshake stalls enabled by MULTICYCLE_CONTROL_MEM_WAIT_EN.
module multicycle_control_fsm
    import multicycle_pkg::*;
#(
    parameter int unsigned OP_W     = 6,
    parameter int unsigned FUNCT_W  = 6,
    parameter int unsigned ALUCTL_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_W-1:0]     op,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_en,
    output logic                iord,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_src,
    output logic [ALUCTL_W-1:0] alu_ctl,
    output logic [3:0]          dbg_state
);

    state_e state_q, state_d, cur_state;
    aluop_e aluop;
    logic   mem_ok;
    logic   pc_write, branch, mem_write_raw, ir_write_raw, reg_write_raw;

`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok           = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset is seen combinationally so mux selects show FETCH values immediately.
    assign cur_state = rst ? StFetch : state_q;

    always_comb begin
        state_d       = StFetch;
        pc_write      = 1'b0;
        branch        = 1'b0;
        iord          = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write_raw = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        pc_src        = PCSRC_ALU;
        aluop         = AluOpAdd;
        case (cur_state)
            StFetch: begin
                alu_src_b    = SRCB_FOUR;
                ir_write_raw = mem_ok;
                pc_write     = mem_ok;
                state_d      = mem_ok ? StDecode : StFetch;
            end
            StDecode: begin
                alu_src_b = SRCB_IMM_SH2;
                case (op)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StExecute;
                    OP_BEQ:       state_d = StBranch;
                    OP_ADDI:      state_d = StAddiEx;
                    OP_J:         state_d = StJump;
                    default:      state_d = StFetch;
                endcase
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (op == OP_SW) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                iord    = 1'b1;
                state_d = mem_ok ? StMemWb : StMemRd;
            end
            StMemWb: begin
                mem_to_reg    = 1'b1;
                reg_write_raw = 1'b1;
            end
            StMemWr: begin
                iord          = 1'b1;
                mem_write_raw = mem_ok;
                state_d       = mem_ok ? StFetch : StMemWr;
            end
            StExecute: begin
                alu_src_a = 1'b1;
                aluop     = AluOpFunct;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_dst       = 1'b1;
                reg_write_raw = 1'b1;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                aluop     = AluOpSub;
                pc_src    = PCSRC_ALUOUT;
                branch    = 1'b1;
            end
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_write_raw = 1'b1;
            end
            StJump: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

    assign pc_en     = ~rst & (pc_write | (branch & zero));
    assign mem_write = ~rst & mem_write_raw;
    assign ir_write  = ~rst & ir_write_raw;
    assign reg_write = ~rst & reg_write_raw;
    assign dbg_state = cur_state;

    alu_decoder #(
        .FUNCT_W  (FUNCT_W),
        .ALUCTL_W (ALUCTL_W)
    ) u_alu_decoder (
        .aluop   (aluop),
        .funct   (funct),
        .alu_ctl (alu_ctl)
    );

endmodule
